// File: rtl/whack_pkg.sv
// rtl/whack_pkg.sv - shared types, constants and BCD helpers for the mole judge
package whack_pkg;

  localparam int N_HOLES_DEF = 8;

  typedef enum logic [1:0] {
    WAIT  = 2'd0,
    ARMED = 2'd1,
    HIT   = 2'd2,
    MISS  = 2'd3
  } judge_state_t;

  typedef logic [7:0] bcd2_t;

  localparam bcd2_t BCD_MAX = 8'h99;

  // Two-digit BCD increment that holds at 99 instead of wrapping.
  function automatic bcd2_t bcd_inc_sat(input bcd2_t v);
    bcd2_t r;
    if (v == BCD_MAX) begin
      r = v;
    end else if (v[3:0] == 4'd9) begin
      r = {v[7:4] + 4'd1, 4'd0};
    end else begin
      r = {v[7:4], v[3:0] + 4'd1};
    end
    return r;
  endfunction

endpackage

// File: rtl/key_debounce.sv
// rtl/key_debounce.sv - one key: 2-flop synchronizer, stability counter, debounced level and registered rise
module key_debounce #(
  parameter int DEB_CYCLES = 500000
) (
  input  logic clk_50,
  input  logic rst_n,
  input  logic key,
  output logic key_db,
  output logic rise
);

  localparam int CW = $clog2(DEB_CYCLES + 1);

  logic          sync1;
  logic          sync2;
  logic [CW-1:0] cnt;
  logic          key_db_d;

  // Bring the raw key into the clk_50 domain.
  always_ff @(posedge clk_50 or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
    end else begin
      sync1 <= key;
      sync2 <= sync1;
    end
  end

  // Accept a new level only after it has differed from key_db for DEB_CYCLES straight cycles.
  always_ff @(posedge clk_50 or negedge rst_n) begin
    if (!rst_n) begin
      cnt    <= '0;
      key_db <= 1'b0;
    end else if (sync2 == key_db) begin
      cnt <= '0;
    end else if (cnt == CW'(DEB_CYCLES - 1)) begin
      cnt    <= '0;
      key_db <= sync2;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  // Registered rising edge of the debounced level, one cycle after key_db rises.
  always_ff @(posedge clk_50 or negedge rst_n) begin
    if (!rst_n) begin
      key_db_d <= 1'b0;
      rise     <= 1'b0;
    end else begin
      key_db_d <= key_db;
      rise     <= key_db & ~key_db_d;
    end
  end

endmodule

// File: rtl/mole_hit_judge.sv
// rtl/mole_hit_judge.sv - debounces hole keys and judges one press per mole; MISS_COUNT_EN adds miss_bcd
import whack_pkg::*;

module mole_hit_judge #(
  parameter int N_HOLES    = N_HOLES_DEF,
  parameter int DEB_CYCLES = 500000
) (
  input  logic               clk_50,
  input  logic               rst_n,
  input  logic [N_HOLES-1:0] key,
  input  logic [N_HOLES-1:0] mole_pos,
  input  logic               mole_new,
  output logic               hit,
  output logic               hit_pulse,
  output bcd2_t              score_bcd
`ifdef MISS_COUNT_EN
  ,
  output bcd2_t              miss_bcd
`endif
);

  logic [N_HOLES-1:0] key_db;
  logic [N_HOLES-1:0] press;
  judge_state_t       state;
  judge_state_t       state_next;
  logic               do_hit;
  logic               do_miss;
  logic               do_withdraw;
  logic               pos_onehot;

  genvar gi;
  generate
    for (gi = 0; gi < N_HOLES; gi++) begin : g_key
      key_debounce #(
        .DEB_CYCLES(DEB_CYCLES)
      ) u_deb (
        .clk_50 (clk_50),
        .rst_n  (rst_n),
        .key    (key[gi]),
        .key_db (key_db[gi]),
        .rise   (press[gi])
      );
    end
  endgenerate

  assign pos_onehot = (mole_pos != '0) && ((mole_pos & (mole_pos - 1'b1)) == '0);

  // Judge state register.
  always_ff @(posedge clk_50 or negedge rst_n) begin
    if (!rst_n) begin
      state <= WAIT;
    end else begin
      state <= state_next;
    end
  end

  // Next state: a new mole always re-arms; only the first press while armed is judged.
  always_comb begin
    state_next  = state;
    do_hit      = 1'b0;
    do_miss     = 1'b0;
    do_withdraw = 1'b0;
    if (mole_new) begin
      state_next = ARMED;
    end else if (state == ARMED) begin
      if (press != '0) begin
        if (pos_onehot && (press == mole_pos)) begin
          state_next = HIT;
          do_hit     = 1'b1;
        end else begin
          state_next = MISS;
          do_miss    = 1'b1;
        end
      end else if (mole_pos == '0) begin
        state_next  = WAIT;
        do_withdraw = 1'b1;
      end
    end
  end

  // Score, hit pulse and the hit level that follows the held correct key.
  always_ff @(posedge clk_50 or negedge rst_n) begin
    if (!rst_n) begin
      hit_pulse <= 1'b0;
      hit       <= 1'b0;
      score_bcd <= 8'h00;
    end else begin
      hit_pulse <= do_hit;
      hit       <= (state == HIT) && |(key_db & mole_pos);
      if (do_hit) begin
        score_bcd <= bcd_inc_sat(score_bcd);
      end
    end
  end

`ifdef MISS_COUNT_EN
  // Wrong presses and unjudged withdrawals both count as misses.
  always_ff @(posedge clk_50 or negedge rst_n) begin
    if (!rst_n) begin
      miss_bcd <= 8'h00;
    end else if (do_miss || do_withdraw) begin
      miss_bcd <= bcd_inc_sat(miss_bcd);
    end
  end
`endif

endmodule

// File: tb/tb_mole_hit_judge.sv
// tb/tb_mole_hit_judge.sv - randomized scoreboard bench for mole_hit_judge
module tb_mole_hit_judge;

  localparam int DEB = 16;
  localparam int S_WAIT = 0, S_ARMED = 1, S_HIT = 2, S_MISS = 3;

  logic       clk_50 = 1'b0;
  logic       rst_n;
  logic [7:0] key;
  logic [7:0] mole_pos;
  logic       mole_new;
  logic       hit;
  logic       hit_pulse;
  logic [7:0] score_bcd;
`ifdef MISS_COUNT_EN
  logic [7:0] miss_bcd;
`endif

  int n_checks = 0;
  int n_errors = 0;

  int         m_state = S_WAIT;
  int         m_score = 0;
  int         m_miss  = 0;
  logic [7:0] m_pos   = 8'h00;
  logic [7:0] exp_q[$];

  mole_hit_judge #(
    .N_HOLES   (8),
    .DEB_CYCLES(DEB)
  ) u_dut (
    .clk_50   (clk_50),
    .rst_n    (rst_n),
    .key      (key),
    .mole_pos (mole_pos),
    .mole_new (mole_new),
    .hit      (hit),
    .hit_pulse(hit_pulse),
    .score_bcd(score_bcd)
`ifdef MISS_COUNT_EN
    ,
    .miss_bcd (miss_bcd)
`endif
  );

  always #10 clk_50 = ~clk_50;

  function automatic logic [7:0] to_bcd(input int s);
    return 8'(((s / 10) << 4) | (s % 10));
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: every hit_pulse must match the next expected score.
  always @(negedge clk_50) begin
    if (rst_n === 1'b1 && hit_pulse === 1'b1) begin
      n_checks++;
      if (exp_q.size() == 0) begin
        n_errors++;
        $display("FAIL unexpected_hit_pulse: got score %0h expected no pulse", score_bcd);
      end else begin
        logic [7:0] e;
        e = exp_q.pop_front();
        if (score_bcd !== e) begin
          n_errors++;
          $display("FAIL hit_score: got %0h expected %0h", score_bcd, e);
        end
      end
    end
  end

  task automatic new_mole(input logic [7:0] pos);
    @(posedge clk_50); #1;
    mole_pos = pos;
    mole_new = 1'b1;
    @(posedge clk_50); #1;
    mole_new = 1'b0;
    m_pos   = pos;
    m_state = S_ARMED;
    if (pos == 8'h00) begin
      m_state = S_WAIT;
      m_miss++;
    end
    repeat (2) @(posedge clk_50);
    #1;
  endtask

  task automatic withdraw();
    @(posedge clk_50); #1;
    mole_pos = 8'h00;
    if (m_state == S_ARMED) begin
      m_state = S_WAIT;
      m_miss++;
    end
    m_pos = 8'h00;
    repeat (3) @(posedge clk_50);
    #1;
  endtask

  task automatic press(input logic [7:0] p);
    int nb;
    nb = $urandom_range(0, 5);
    if (m_state == S_ARMED) begin
      if ($onehot(m_pos) && p == m_pos) begin
        m_state = S_HIT;
        if (m_score < 99) m_score++;
        exp_q.push_back(to_bcd(m_score));
      end else begin
        m_state = S_MISS;
        m_miss++;
      end
    end
    for (int b = 0; b < nb; b++) begin
      key = (b % 2 == 0) ? p : 8'h00;
      repeat ($urandom_range(1, 3)) @(posedge clk_50);
      #1;
    end
    key = p;
    repeat (DEB + 8) @(posedge clk_50);
    @(negedge clk_50);
    chk("hit_held", {31'd0, hit}, {31'd0, (m_state == S_HIT) && ((p & m_pos) != 8'h00)});
    key = 8'h00;
    repeat (DEB + 8) @(posedge clk_50);
    @(negedge clk_50);
    chk("hit_released", {31'd0, hit}, 32'd0);
  endtask

  function automatic logic [7:0] rand_onehot();
    return 8'(1 << $urandom_range(0, 7));
  endfunction

  initial begin
    rst_n    = 1'b0;
    key      = 8'hFF;
    mole_pos = 8'h00;
    mole_new = 1'b0;
    repeat (3) @(posedge clk_50);
    @(negedge clk_50);
    chk("reset_hit", {31'd0, hit}, 32'd0);
    chk("reset_hit_pulse", {31'd0, hit_pulse}, 32'd0);
    chk("reset_score", {24'd0, score_bcd}, 32'h00);
`ifdef MISS_COUNT_EN
    chk("reset_miss", {24'd0, miss_bcd}, 32'h00);
`endif
    rst_n = 1'b1;
    repeat (DEB + 10) @(posedge clk_50);
    #1;
    key = 8'h00;
    repeat (DEB + 10) @(posedge clk_50);
    #1;
    chk("no_score_from_reset_keys", {24'd0, score_bcd}, 32'h00);

    // Correct bounced press scores once; re-press while in HIT only re-asserts hit.
    new_mole(8'h04);
    press(8'h04);
    press(8'h04);
    chk("score_after_first_hit", {24'd0, score_bcd}, 32'h01);

    // Wrong key misses; the correct key afterwards is ignored.
    new_mole(8'h04);
    press(8'h20);
    press(8'h04);
    chk("score_after_miss", {24'd0, score_bcd}, 32'h01);

    // Two keys at once is a miss.
    new_mole(8'h04);
    press(8'h24);

    // A press landing in the same cycle as mole_new only re-arms.
    new_mole(8'h04);
    key = 8'h04;
    repeat (DEB + 3) @(posedge clk_50);
    #1;
    mole_new = 1'b1;
    @(posedge clk_50); #1;
    mole_new = 1'b0;
    repeat (8) @(posedge clk_50);
    @(negedge clk_50);
    chk("same_cycle_no_hit", {31'd0, hit}, 32'd0);
    key = 8'h00;
    repeat (DEB + 8) @(posedge clk_50);
    #1;
    press(8'h04);

    // Withdrawal without a judgement.
    new_mole(8'h10);
    withdraw();
    press(8'h10);

    // Randomized rounds.
    for (int r = 0; r < 50; r++) begin
      int sel;
      int act;
      logic [7:0] pos;
      sel = $urandom_range(0, 9);
      if (sel == 0) pos = 8'h00;
      else if (sel == 1) pos = rand_onehot() | rand_onehot();
      else pos = rand_onehot();
      new_mole(pos);
      act = $urandom_range(0, 4);
      case (act)
        0: press((pos == 8'h00) ? rand_onehot() : pos);
        1: press(rand_onehot());
        2: press(pos | rand_onehot());
        3: withdraw();
        default: ;
      endcase
      if ($urandom_range(0, 1) == 1) press(($urandom_range(0, 1) == 1) ? pos : rand_onehot());
    end

    // Drive the score into saturation and beyond.
    while (m_score < 99) begin
      logic [7:0] pos;
      pos = rand_onehot();
      new_mole(pos);
      press(pos);
    end
    for (int k = 0; k < 2; k++) begin
      logic [7:0] pos;
      pos = rand_onehot();
      new_mole(pos);
      press(pos);
      chk("score_saturated", {24'd0, score_bcd}, 32'h99);
    end

    repeat (5) @(posedge clk_50);
    @(negedge clk_50);
    chk("final_score", {24'd0, score_bcd}, {24'd0, to_bcd(m_score)});
    chk("pending_hits", exp_q.size(), 32'd0);
`ifdef MISS_COUNT_EN
    chk("final_miss", {24'd0, miss_bcd}, {24'd0, to_bcd((m_miss > 99) ? 99 : m_miss)});
`endif
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
